// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
package mux_arb_pkg;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned SEL_W = 2;

   typedef enum logic [1:0] {
      StIdle,
      StGrant,
      StRelease
   } arb_state_e;

   function automatic logic [N_REQ-1:0] onehot_idx(input logic [SEL_W-1:0] idx);
      logic [N_REQ-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter driving the mux select.
interface mux4_rr_arbiter_if;
   import mux_arb_pkg::*;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic [SEL_W-1:0] sel;
   logic             valid;
   logic             timeout;

   modport master (
      output req,
      input  gnt,
      input  sel,
      input  valid,
      input  timeout
   );

   modport slave (
      input  req,
      output gnt,
      output sel,
      output valid,
      output timeout
   );

endinterface

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first asserted req after 'last', wrapping to 'last'.
module rr_pick4
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] last,
   output logic [SEL_W-1:0] pick,
   output logic             found
);

   logic [SEL_W-1:0] idx;

   // Walk from farthest to nearest so the nearest asserted requester is written last and wins.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         idx = last + SEL_W'(i);
         if (req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner selection for a shared 4:1 mux with a bounded hold time and a
// one-cycle dead gap on every handover.
module mux4_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned CNT_W    = 8
) (
   input logic              clk,
   input logic              rst,
   mux4_rr_arbiter_if.slave bus
);

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SEL_W-1:0] last_q, last_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             timeout_q, timeout_d;

   logic [SEL_W-1:0] pick;
   logic             found;

   rr_pick4 u_pick (
      .req   (bus.req),
      .last  (last_q),
      .pick  (pick),
      .found (found)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      gnt_d     = gnt_q;
      sel_d     = sel_q;
      timeout_d = 1'b0;

      unique case (state_q)
         StIdle, StRelease: begin
            if (found) begin
               state_d = StGrant;
               gnt_d   = onehot_idx(pick);
               sel_d   = pick;
               last_d  = pick;
               cnt_d   = CNT_W'(1);
            end else begin
               state_d = StIdle;
               gnt_d   = '0;
            end
         end
         StGrant: begin
            // A natural release takes precedence over the hold-limit timeout.
            if (!bus.req[sel_q]) begin
               state_d = StRelease;
               gnt_d   = '0;
            end else if (cnt_q == CNT_W'(MAX_HOLD)) begin
               state_d   = StRelease;
               gnt_d     = '0;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         last_q    <= SEL_W'(N_REQ - 1);
         gnt_q     <= '0;
         sel_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         gnt_q     <= gnt_d;
         sel_q     <= sel_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.sel     = sel_q;
   assign bus.valid   = |gnt_q;
   assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed scoreboard bench plus a random-request phase with per-cycle property checks.
module tb_mux4_rr_arbiter;

   localparam int unsigned MaxHold = 8;
   localparam int unsigned Starve  = 3 * (MaxHold + 1) + 1;

   typedef struct {
      int         cyc;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       valid;
      logic       timeout;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   failures;
   bit   rand_phase;
   exp_t exp_q[$];

   int run_len;
   int wait_cnt[4];

   mux4_rr_arbiter_if bus_if ();

   mux4_rr_arbiter #(
      .MAX_HOLD (MaxHold),
      .CNT_W    (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Drive req for the coming edge and queue what the outputs must show after it.
   task automatic drive(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                        input logic v, input logic t);
      exp_t e;
      bus_if.req = r;
      e.cyc      = cyc + 1;
      e.gnt      = g;
      e.sel      = s;
      e.valid    = v;
      e.timeout  = t;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: compares each queued expectation on its cycle.
   always @(negedge clk) begin
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         checks++;
         failures++;
         $display("FAIL stale_expect cyc=%0d expected_cyc=%0d", cyc, e.cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         e = exp_q.pop_front();
         checks++;
         if (bus_if.gnt !== e.gnt || bus_if.sel !== e.sel || bus_if.valid !== e.valid ||
             bus_if.timeout !== e.timeout) begin
            failures++;
            $display("FAIL outputs cyc=%0d got gnt=%b sel=%0d valid=%b timeout=%b want gnt=%b sel=%0d valid=%b timeout=%b",
                     cyc, bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.timeout,
                     e.gnt, e.sel, e.valid, e.timeout);
         end
      end
   end

   // Property checks during the random phase.
   always @(negedge clk) begin
      if (rand_phase) begin
         checks++;
         if ((bus_if.gnt & (bus_if.gnt - 4'd1)) != 4'd0) begin
            failures++;
            $display("FAIL onehot cyc=%0d gnt=%b", cyc, bus_if.gnt);
         end
         checks++;
         if (bus_if.valid !== (|bus_if.gnt)) begin
            failures++;
            $display("FAIL valid_or cyc=%0d valid=%b gnt=%b", cyc, bus_if.valid, bus_if.gnt);
         end
         checks++;
         if (bus_if.timeout && bus_if.valid) begin
            failures++;
            $display("FAIL timeout_valid cyc=%0d timeout=1 valid=1", cyc);
         end
         if (bus_if.gnt != 4'd0) run_len++;
         else run_len = 0;
         checks++;
         if (run_len > int'(MaxHold)) begin
            failures++;
            $display("FAIL hold_limit cyc=%0d run=%0d max=%0d", cyc, run_len, MaxHold);
         end
         for (int k = 0; k < 4; k++) begin
            if (bus_if.req[k] && !bus_if.gnt[k]) wait_cnt[k]++;
            else wait_cnt[k] = 0;
            checks++;
            if (wait_cnt[k] > int'(Starve)) begin
               failures++;
               $display("FAIL starve cyc=%0d req=%0d waited=%0d bound=%0d", cyc, k, wait_cnt[k],
                        Starve);
               wait_cnt[k] = 0;
            end
         end
      end
   end

   initial begin
      logic [3:0] rq;
      logic [3:0] prev_gnt;
      checks     = 0;
      failures   = 0;
      rand_phase = 1'b0;
      run_len    = 0;
      for (int k = 0; k < 4; k++) wait_cnt[k] = 0;
      rst        = 1'b1;
      bus_if.req = 4'b0000;

      // Reset state
      drive(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
      drive(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
      rst = 1'b0;

      // Single requester, natural release after 3 grant cycles
      for (int i = 0; i < 3; i++) drive(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
      drive(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
      drive(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

      // Re-reset so rotation starts at requester 0, then full contention
      rst = 1'b1;
      drive(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
      rst = 1'b0;
      for (int o = 0; o < 5; o++) begin
         logic [1:0] s;
         logic [3:0] oh;
         s  = 2'(o % 4);
         oh = 4'b0001 << s;
         for (int i = 0; i < int'(MaxHold); i++) drive(4'b1111, oh, s, 1'b1, 1'b0);
         drive(4'b1111, 4'b0000, s, 1'b0, 1'b1);
      end
      // Last drive left the arbiter in RELEASE; no requests sends it to IDLE
      drive(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

      // Make last=1, then 0011 in IDLE must grant requester 0
      drive(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
      drive(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
      drive(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
      drive(4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
      drive(4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0);
      drive(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
      drive(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
      drive(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);

      // Owner drops req exactly when cnt==MAX_HOLD: natural release, no timeout
      for (int i = 0; i < int'(MaxHold); i++) drive(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
      drive(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
      drive(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

      // Lone requester times out and is re-granted after the dead cycle
      for (int i = 0; i < int'(MaxHold); i++) drive(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
      drive(4'b1000, 4'b0000, 2'd3, 1'b0, 1'b1);
      drive(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
      drive(4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);
      drive(4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);

      // Reset mid-grant, then requester 0 wins under full contention
      for (int i = 0; i < 3; i++) drive(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
      rst = 1'b1;
      drive(4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
      rst = 1'b0;
      drive(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
      drive(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
      drive(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
      drive(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

      // Random sticky requests with property checks
      rq         = 4'b0000;
      prev_gnt   = 4'b0000;
      rand_phase = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 7) == 0) rq[k] = ~rq[k];
         end
         bus_if.req = rq;
         @(posedge clk);
         #1;
         prev_gnt = bus_if.gnt;
      end
      rand_phase = 1'b0;
      @(posedge clk);
      #1;

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain left=%0d want=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 mux datapath among four requesters. It grants exclusive ownership to one requester at a time and drives the mux select to that requester's index. Ownership is bounded by a hold limit so no requester starves. It sits directly in front of the 4:1 mux; its sel output feeds the mux select port.

Parameters:
MAX_HOLD, 8, maximum consecutive grant cycles per ownership; legal range 1..255.
CNT_W, 8, hold-counter width; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
clk  input  1  rising-edge clock; the block has one clock.
rst  input  1  reset; synchronous and active-high.
req  input  4  request vector; req[k] is held high while requester k wants the mux.
gnt  output 4  registered one-hot grant; all zero when there is no owner.
sel  output 2  registered mux select; equals the index of the current owner.
valid  output 1  high while any grant is active; equals |gnt.
timeout  output 1  one-cycle pulse when a grant is forcibly ended by MAX_HOLD.

Behaviour:
- Reset: on a clk edge with rst=1, the block sets gnt=0, sel=0, valid=0, timeout=0, state=IDLE, cnt=0 and last=3. With last=3, req[0] has highest priority after reset. rst overrides all other inputs, including mid-grant.
- States: IDLE, GRANT, RELEASE.
- Arbitration happens only in IDLE or RELEASE. The pick is the first asserted req searching (last+1), (last+2), (last+3), (last+4) mod 4.
  - If a requester is found: the next state is GRANT, and on that edge gnt=onehot(pick), sel=pick, last=pick, cnt=1.
  - If no req is asserted: IDLE stays in IDLE; RELEASE goes to IDLE.
- Latency: one cycle from req sampled to gnt visible.
- GRANT, in priority order:
  - If req[owner]=0: go to RELEASE with gnt=0 and timeout=0 (natural release). This wins even when cnt==MAX_HOLD.
  - Else if cnt==MAX_HOLD: go to RELEASE with gnt=0 and timeout=1 for exactly that one cycle.
  - Else: stay in GRANT, cnt=cnt+1, gnt and sel unchanged.
- Requests from non-owners during GRANT are ignored; they are not queued beyond the req level itself.
- RELEASE always lasts at least one cycle with gnt=0. This is a dead cycle for mux handover, and arbitration is evaluated in the same cycle.
- Back-to-back ownership by the same requester is possible only when no other req is asserted, because the search ends at last+4 = last.
- sel holds the last owner's index in IDLE and RELEASE. Consumers must qualify sel with valid.
- The gnt one-hot invariant holds in all states. timeout is never high while valid=1.
- The hold counter never exceeds MAX_HOLD and never wraps.

Decomposition:
- Package mux_arb_pkg holds:
  - state enum (IDLE, GRANT, RELEASE);
  - N_REQ=4 and SEL_W=2 constants;
  - a onehot-from-index function.
- Sub-module rr_pick4 is a combinational rotating-priority picker:
  - inputs: req[3:0] and last[1:0];
  - outputs: pick[1:0] and found.
- The top level holds the FSM, hold counter and output registers.

Test Plan:
1. Reset, then req=0001 → gnt=0001, sel=00, valid=1 one cycle later. Drop req[0] after 3 grant cycles → next cycle gnt=0000, timeout=0, state RELEASE.
2. req=1111 held constant with MAX_HOLD=8 → grants rotate 0,1,2,3,0. Each grant lasts exactly 8 cycles, with timeout pulsing once per handover and a 1-cycle gnt=0 gap between grants.
3. last=1 with req=0011 asserted in IDLE → req[0] is granted, not req[1]. Then only req[1] high → it is granted after the RELEASE gap.
4. Owner drops req on the cycle cnt==MAX_HOLD → RELEASE with timeout=0.
5. Assert rst for one cycle mid-GRANT (gnt=0100) → next edge gnt=0, sel=0, valid=0. With req=1111 afterwards, req[0] is granted first.
6. Random req for 2000 cycles, with assertions checked every cycle:
   - gnt is one-hot or zero;
   - valid equals |gnt;
   - no grant run exceeds MAX_HOLD cycles;
   - every continuously asserted req is granted within 3*(MAX_HOLD+1)+1 cycles.
